// File: rtl/alu_driver.sv
// Sequences one MIPS R-type operation at a time through an external registered ALU.
// Path is accept -> EXEC -> CAPT -> RESP; a new request can be accepted on the response-transfer edge.
module alu_driver #(
  parameter logic [2:0] ILLEGAL_CTRL = 3'b111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_r,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_illegal,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_ctrl_q, alu_ctrl_d;
  logic        illegal_q, illegal_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_illegal_q, rsp_illegal_d;
  logic [15:0] op_count_q, op_count_d;

  logic [2:0]  dec_ctrl;
  logic        dec_illegal;
  logic        req_fire;
  logic        rsp_fire;

  always_comb begin
    dec_ctrl    = ILLEGAL_CTRL;
    dec_illegal = 1'b1;
    case (req_funct)
      6'h20: begin dec_ctrl = 3'b000; dec_illegal = 1'b0; end
      6'h22: begin dec_ctrl = 3'b001; dec_illegal = 1'b0; end
      6'h26: begin dec_ctrl = 3'b010; dec_illegal = 1'b0; end
      default: ;
    endcase
  end

  // In RESP the requester sees rsp_ready directly so a new op can overlap the response transfer.
  always_comb begin
    req_ready = 1'b0;
    if (reset) begin
      if (state_q == IDLE)
        req_ready = 1'b1;
      else if (state_q == RESP)
        req_ready = rsp_ready;
    end
  end

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid_q && rsp_ready;

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_ctrl_d    = alu_ctrl_q;
    illegal_d     = illegal_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
    op_count_d    = op_count_q;

    case (state_q)
      EXEC: state_d = CAPT;
      CAPT: begin
        rsp_data_d    = alu_r;
        rsp_zero_d    = alu_zero;
        rsp_illegal_d = illegal_q;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end
      default: ;
    endcase

    if (rsp_fire) begin
      rsp_valid_d = 1'b0;
      op_count_d  = op_count_q + 16'd1;
      state_d     = IDLE;
    end

    // Only possible in IDLE or in RESP alongside rsp_fire, so it overrides the IDLE return.
    if (req_fire) begin
      alu_a_d    = req_a;
      alu_b_d    = req_b;
      alu_ctrl_d = dec_ctrl;
      illegal_d  = dec_illegal;
      state_d    = EXEC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_ctrl_q    <= 3'b000;
      illegal_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_ctrl_q    <= alu_ctrl_d;
      illegal_q     <= illegal_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
      op_count_q    <= op_count_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_illegal = rsp_illegal_q;
  assign op_count    = op_count_q;

  a_valid_only_in_resp: assert property (@(posedge clk) disable iff (!reset)
    rsp_valid_q == (state_q == RESP));

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a behavioural registered ALU.
module tb_alu_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_r = '0;
  logic        alu_zero = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_illegal;
  logic [15:0] op_count;

  int          nvec = 0;
  int          nmis = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  alu_driver dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_r(alu_r), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal), .op_count(op_count)
  );

  // Registered ALU: operands sampled on the edge ending EXEC, result visible in CAPT.
  always @(posedge clk) begin
    logic [31:0] r;
    case (alu_ctrl)
      3'b000:  r = alu_a + alu_b;
      3'b001:  r = alu_a - alu_b;
      3'b010:  r = alu_a ^ alu_b;
      default: r = 32'd0;
    endcase
    alu_r    <= r;
    alu_zero <= (r == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the driver in IDLE; consumes the response immediately.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] ectrl, input logic [31:0] edata,
                        input logic ezero, input logic eill);
    req_valid = 1'b1; req_funct = f; req_a = a; req_b = b; rsp_ready = 1'b1;
    chk("idle_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("exec_alu_ctrl", alu_ctrl, ectrl);
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_req_ready", req_ready, 0);
    step();
    chk("capt_rsp_valid", rsp_valid, 0);
    chk("capt_alu_ctrl", alu_ctrl, ectrl);
    step();
    chk("resp_rsp_valid", rsp_valid, 1);
    chk("resp_rsp_data", rsp_data, edata);
    chk("resp_rsp_zero", rsp_zero, ezero);
    chk("resp_rsp_illegal", rsp_illegal, eill);
    step();
    exp_cnt = exp_cnt + 16'd1;
    chk("post_op_count", op_count, exp_cnt);
    chk("post_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_funct = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    step();
    reset = 1'b1;
    #1;
    chk("rel_req_ready", req_ready, 1);
    @(negedge clk);

    run_op(6'h20, 32'd5, 32'd7, 3'b000, 32'd12, 1'b0, 1'b0);
    run_op(6'h22, 32'hDEADBEEF, 32'hDEADBEEF, 3'b001, 32'd0, 1'b1, 1'b0);
    run_op(6'h20, 32'hFFFFFFFF, 32'd1, 3'b000, 32'd0, 1'b1, 1'b0);
    run_op(6'h24, 32'd9, 32'd3, 3'b111, 32'd0, 1'b1, 1'b1);
    run_op(6'h26, 32'hAAAA5555, 32'h0000FFFF, 3'b010, 32'hAAAAAAAA, 1'b0, 1'b0);

    // Response held under backpressure, then overlapped with a new accept.
    req_valid = 1'b1; req_funct = 6'h20; req_a = 32'd100; req_b = 32'd23; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 32'd123);
      chk("bp_req_ready", req_ready, 0);
      step();
    end
    chk("bp_op_count", op_count, exp_cnt);
    req_valid = 1'b1; req_funct = 6'h26; req_a = 32'hF0F0F0F0; req_b = 32'hFFFF0000; rsp_ready = 1'b1;
    #1;
    chk("ovl_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk("ovl_op_count", op_count, exp_cnt);
    chk("ovl_rsp_valid", rsp_valid, 0);
    chk("ovl_alu_a", alu_a, 32'hF0F0F0F0);
    chk("ovl_alu_ctrl", alu_ctrl, 3'b010);
    step();
    step();
    chk("ovl_rsp_valid2", rsp_valid, 1);
    chk("ovl_rsp_data", rsp_data, 32'h0F0FF0F0);
    step();
    exp_cnt = exp_cnt + 16'd1;
    chk("ovl_op_count2", op_count, exp_cnt);

    // Reset while the operation sits in EXEC.
    req_valid = 1'b1; req_funct = 6'h20; req_a = 32'd1; req_b = 32'd2;
    step();
    req_valid = 1'b0;
    chk("mid_alu_a_pre", alu_a, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_alu_a", alu_a, 0);
    chk("mid_alu_ctrl", alu_ctrl, 0);
    chk("mid_op_count", op_count, 0);
    chk("mid_req_ready", req_ready, 0);
    step();
    reset = 1'b1;
    exp_cnt = '0;
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (rsp_valid) seen++;
        step();
      end
      chk("mid_no_rsp", seen, 0);
    end
    chk("mid_op_count_post", op_count, 0);

    // Jump the counter near its top instead of running 65536 operations.
    force dut.op_count_q = 16'hFFFE;
    step();
    release dut.op_count_q;
    #1;
    exp_cnt = 16'hFFFE;
    chk("wrap_preload", op_count, 16'hFFFE);
    @(negedge clk);
    run_op(6'h20, 32'd2, 32'd2, 3'b000, 32'd4, 1'b0, 1'b0);
    run_op(6'h22, 32'd2, 32'd3, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("wrap_zero", op_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
